slow_control_bit_shifter: RTL and testbench

// Downstream stage of the slow-control/read-scope parameter generator.
// - Drains 16-bit words from the external parameter FIFO and serialises them MSB-first into the MICROROC shift register.
// - Drives SR_CK, SR_IN and SR_RSTB, plus the SELECT line that picks the slow-control or read-scope register.
// - Starts on the generator's ParameterDone pulse; flags completion for the load-done logic.

---
 rtl/slow_control_bit_shifter_if.sv | 39 +++
 rtl/slow_control_bit_shifter.sv | 158 +++++++++++++++
 tb/tb_slow_control_bit_shifter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_control_bit_shifter_if.sv
// Bus between the parameter generator / parameter FIFO / MICROROC chip side
// (master) and the slow-control bit shifter (slave).
//
// Signals
//   Start                         generator ParameterDone pulse
//   SlowControlOrReadScopeSelect  1 = slow control load, 0 = read scope load
//   FifoEmpty, FifoReadEn, FifoData  parameter FIFO read port
//   SR_CK, SR_IN, SR_RSTB, SELECT    chip shift-register pins
//   Busy, Done                    load status toward the load-done logic
//   fsm_state                     debug view of the shifter FSM state
//
// FIFO handshake: !FifoEmpty is the "valid" of the FIFO and FifoReadEn is the
// pop/"ready" of the shifter. A word leaves the FIFO in exactly the cycles
// where FifoReadEn=1, and the shifter only raises FifoReadEn while
// FifoEmpty=0. The popped word appears on FifoData one Clk after the pop.
interface slow_control_bit_shifter_if;
  logic        Start;
  logic        SlowControlOrReadScopeSelect;
  logic        FifoEmpty;
  logic        FifoReadEn;
  logic [15:0] FifoData;
  logic        SR_CK;
  logic        SR_IN;
  logic        SR_RSTB;
  logic        SELECT;
  logic        Busy;
  logic        Done;
  logic [2:0]  fsm_state;

  modport master (
    output Start, SlowControlOrReadScopeSelect, FifoEmpty, FifoData,
    input  FifoReadEn, SR_CK, SR_IN, SR_RSTB, SELECT, Busy, Done, fsm_state
  );

  modport slave (
    input  Start, SlowControlOrReadScopeSelect, FifoEmpty, FifoData,
    output FifoReadEn, SR_CK, SR_IN, SR_RSTB, SELECT, Busy, Done, fsm_state
  );
endinterface

// File: rtl/slow_control_bit_shifter.sv
// Slow-control / read-scope bit shifter.
// Drains 16-bit words from the parameter FIFO and serialises them MSB-first
// into the MICROROC shift register (SR_CK / SR_IN / SR_RSTB), after holding
// SR_RSTB low for RST_CYCLES. SELECT picks the target register and is latched
// from the mode bit when a load starts.
//
// Ports
//   Clk    system clock
//   reset  asynchronous reset, active-high
//   bus    slave side of slow_control_bit_shifter_if (see interface header)
//
// Parameters
//   HALF_PERIOD  Clk cycles per SR_CK half period (1..255)
//   SC_WORDS     words per slow-control load
//   RS_WORDS     words per read-scope load
//   RST_CYCLES   Clk cycles SR_RSTB is held low (1..256)
module slow_control_bit_shifter #(
  parameter int HALF_PERIOD = 4,
  parameter int SC_WORDS    = 37,
  parameter int RS_WORDS    = 4,
  parameter int RST_CYCLES  = 16
) (
  input logic                     Clk,
  input logic                     reset,
  slow_control_bit_shifter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_CHIP = 3'd1,
    S_FETCH    = 3'd2,
    S_LOAD     = 3'd3,
    S_SHIFT    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [5:0] SC_W     = 6'(SC_WORDS);
  localparam logic [5:0] RS_W     = 6'(RS_WORDS);

  state_t      state;
  logic [5:0]  word_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  phase_cnt;  // SR_CK half-period counter, also times the chip reset
  logic [15:0] shreg;
  logic        sr_ck;
  logic        sr_in;
  logic        sr_rstb;
  logic        select_q;
  logic        busy;
  logic        done;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      shreg     <= '0;
      sr_ck     <= 1'b0;
      sr_in     <= 1'b0;
      sr_rstb   <= 1'b1;
      select_q  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (bus.Start) begin
            select_q  <= bus.SlowControlOrReadScopeSelect;
            word_cnt  <= bus.SlowControlOrReadScopeSelect ? SC_W : RS_W;
            busy      <= 1'b1;
            sr_rstb   <= 1'b0;
            phase_cnt <= '0;
            state     <= S_RST_CHIP;
          end
        end

        S_RST_CHIP: begin
          if (phase_cnt == RST_LAST) begin
            sr_rstb   <= 1'b1;
            phase_cnt <= '0;
            state     <= S_FETCH;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        // The pop itself is the combinational FifoReadEn below, so the word
        // is on FifoData by the time LOAD samples it.
        S_FETCH: begin
          if (!bus.FifoEmpty) state <= S_LOAD;
        end

        // First bit of the word goes out together with the capture, which is
        // the first cycle of its SR_CK low phase.
        S_LOAD: begin
          shreg     <= bus.FifoData;
          sr_in     <= bus.FifoData[15];
          sr_ck     <= 1'b0;
          bit_cnt   <= 4'd15;
          phase_cnt <= '0;
          state     <= S_SHIFT;
        end

        S_SHIFT: begin
          if (phase_cnt != PH_LAST) begin
            phase_cnt <= phase_cnt + 8'd1;
          end else begin
            phase_cnt <= '0;
            if (!sr_ck) begin
              sr_ck <= 1'b1;
            end else begin
              // End of the high phase: the chip has sampled this bit.
              sr_ck <= 1'b0;
              shreg <= {shreg[14:0], 1'b0};
              if (bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 4'd1;
                sr_in   <= shreg[14];
              end else begin
                // SR_IN keeps the last bit across the FETCH/LOAD gap.
                word_cnt <= word_cnt - 6'd1;
                if (word_cnt == 6'd1) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  sr_in <= 1'b0;
                  state <= S_DONE;
                end else begin
                  state <= S_FETCH;
                end
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Pop only while the FIFO has data: underflow cannot happen.
  assign bus.FifoReadEn = (state == S_FETCH) && !bus.FifoEmpty;
  assign bus.SR_CK      = sr_ck;
  assign bus.SR_IN      = sr_in;
  assign bus.SR_RSTB    = sr_rstb;
  assign bus.SELECT     = select_q;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_slow_control_bit_shifter.sv
// Bench for slow_control_bit_shifter: three copies with HALF_PERIOD 4, 1
// and 8 run the same loads in parallel, each with its own FIFO model and
// pin monitor. Expected bitstreams come from exp_q (words MSB-first),
// timing from the load-time formula.
module tb_slow_control_bit_shifter;

  localparam int NI = 3;
  localparam int HPS[NI] = '{4, 1, 8};
  localparam int RST_C = 16;
  localparam int K_A5 = 0, K_SPARSE = 1, K_RAND = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start = 1'b0;
  logic        mode = 1'b1;
  logic        mon_clr = 1'b0;
  logic        stall_chk = 1'b0;
  int          avail = 0;
  logic [15:0] fifo_mem[64];
  logic [15:0] exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  wire [31:0] edges_w[NI], bit_err_w[NI], tim_err_w[NI], stall_err_w[NI];
  wire [31:0] done_w_cnt[NI], busy_cyc_w[NI], rst_len_w[NI], rd_ptr_w[NI];
  wire        ck_w[NI], in_w[NI], rstb_w[NI], ren_w[NI], sel_w[NI], busy_w[NI], done_w[NI];

  // Expected bit number i of the load: word i/16, MSB first; 2 = past the end.
  function automatic int exp_bit_at(input int i);
    logic [15:0] w;
    if (i >= 16 * exp_q.size()) return 2;
    w = exp_q[i / 16];
    return int'(w[15 - (i % 16)]);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int HP = HPS[g];
    slow_control_bit_shifter_if ifc();
    slow_control_bit_shifter #(.HALF_PERIOD(HP)) dut (
      .Clk(clk), .reset(rst), .bus(ifc.slave)
    );

    // FIFO model: pop on FifoReadEn, data valid the next cycle.
    int          rd_ptr;
    logic [15:0] fdata;
    assign ifc.Start = start;
    assign ifc.SlowControlOrReadScopeSelect = mode;
    assign ifc.FifoEmpty = (rd_ptr >= avail);
    assign ifc.FifoData = fdata;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= 0;
        fdata  <= 16'h0;
      end else if (mon_clr) begin
        rd_ptr <= 0;
      end else if (ifc.FifoReadEn) begin
        fdata  <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end

    // Pin monitor, sampled mid-cycle.
    logic prev_ck, prev_in, prev_rstb;
    int   run, edges, bit_err, tim_err, stall_err, done_cnt, busy_cyc, rst_len, rlow;
    always @(negedge clk) begin
      if (rst || mon_clr) begin
        prev_ck <= 1'b0; prev_in <= 1'b0; prev_rstb <= 1'b1;
        run <= HP; edges <= 0; bit_err <= 0; tim_err <= 0; stall_err <= 0;
        done_cnt <= 0; busy_cyc <= 0; rst_len <= 0; rlow <= 0;
      end else begin
        if (ifc.SR_CK && !prev_ck) begin
          edges   <= edges + 1;
          bit_err <= bit_err + ((int'(ifc.SR_IN) != exp_bit_at(edges)) ? 1 : 0);
        end
        if (ifc.SR_CK == prev_ck) run <= run + 1;
        else run <= 1;
        tim_err <= tim_err
                 + ((!ifc.SR_CK && prev_ck && run != HP) ? 1 : 0)       // high width
                 + ((ifc.SR_CK && !prev_ck && run < HP) ? 1 : 0)        // low width
                 + ((ifc.SR_CK && prev_ck && ifc.SR_IN != prev_in) ? 1 : 0)
                 + ((ifc.FifoReadEn && ifc.FifoEmpty) ? 1 : 0);
        if (stall_chk && (ifc.SR_CK || ifc.FifoReadEn || !ifc.Busy)) stall_err <= stall_err + 1;
        if (!ifc.SR_RSTB) rlow <= rlow + 1;
        else if (!prev_rstb) begin rst_len <= rlow; rlow <= 0; end
        if (ifc.Busy || ifc.Done) busy_cyc <= busy_cyc + 1;
        if (ifc.Done) done_cnt <= done_cnt + 1;
        prev_ck <= ifc.SR_CK; prev_in <= ifc.SR_IN; prev_rstb <= ifc.SR_RSTB;
      end
    end

    assign edges_w[g] = edges;       assign bit_err_w[g] = bit_err;
    assign tim_err_w[g] = tim_err;   assign stall_err_w[g] = stall_err;
    assign done_w_cnt[g] = done_cnt; assign busy_cyc_w[g] = busy_cyc;
    assign rst_len_w[g] = rst_len;   assign rd_ptr_w[g] = rd_ptr;
    assign ck_w[g] = ifc.SR_CK;      assign in_w[g] = ifc.SR_IN;
    assign rstb_w[g] = ifc.SR_RSTB;  assign ren_w[g] = ifc.FifoReadEn;
    assign sel_w[g] = ifc.SELECT;    assign busy_w[g] = ifc.Busy;
    assign done_w[g] = ifc.Done;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (hp=%0d): got %0d, expected %0d", name, HPS[k], act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, " SR_CK"}, k, int'(ck_w[k]), 0);
      check({tag, " SR_IN"}, k, int'(in_w[k]), 0);
      check({tag, " SR_RSTB"}, k, int'(rstb_w[k]), 1);
      check({tag, " FifoReadEn"}, k, int'(ren_w[k]), 0);
      check({tag, " Busy"}, k, int'(busy_w[k]), 0);
      check({tag, " Done"}, k, int'(done_w[k]), 0);
      check({tag, " SELECT"}, k, int'(sel_w[k]), 1);
    end
  endtask

  function automatic bit all_done();
    for (int k = 0; k < NI; k++) if (done_w_cnt[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_stalled(input int w);
    for (int k = 0; k < NI; k++)
      if (rd_ptr_w[k] != w || edges_w[k] != 16 * w || ck_w[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_fifo(input int kind, input int n);
    exp_q.delete();
    for (int i = 0; i < 64; i++) fifo_mem[i] = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      if (kind == K_A5) fifo_mem[i] = 16'hA5A5;
      else if (kind == K_SPARSE) fifo_mem[i] = (i == 0) ? 16'h8000 : (i == n - 1) ? 16'h0001 : 16'h0000;
      exp_q.push_back(fifo_mem[i]);
    end
  endtask

  task automatic pulse_start(input logic m);
    mode = m; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m;  // mode must only matter at Start
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic mode;        // input: mode bit at Start
    int   kind;        // input: FIFO content pattern
    int   gap_after;   // input: FIFO runs dry after this many words (0 = never)
    int   restart_at;  // input: cycles after Start for a spurious Start (0 = none)
    logic exp_select;  // expected SELECT
    int   exp_words;   // expected words read / 16 edges each
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, K_A5,     0, 0,  1'b1, 37};
    vecs[1] = '{1'b0, K_SPARSE, 0, 0,  1'b0, 4};
    vecs[2] = '{1'b0, K_RAND,   3, 0,  1'b0, 4};
    vecs[3] = '{1'b1, K_RAND,   0, 60, 1'b1, 37};
    for (int i = 4; i < 8; i++)
      vecs[i] = '{1'b0, K_RAND, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 40 : 0, 1'b0, 4};

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle("reset");

    // reset in the middle of a read-scope load
    fill_fifo(K_RAND, 4);
    avail = 6;
    pulse_start(1'b0);
    repeat (100) tick();
    for (int k = 0; k < NI; k++) check("mid-load Busy", k, int'(busy_w[k]), 1);
    rst = 1'b1;
    #1;
    check_idle("async reset");
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      int c;
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      fill_fifo(vecs[v].kind, vecs[v].exp_words);
      avail = (vecs[v].gap_after > 0) ? vecs[v].gap_after : vecs[v].exp_words + 2;
      pulse_start(vecs[v].mode);

      if (vecs[v].gap_after > 0) begin
        c = 0;
        while (c < 20000 && !all_stalled(vecs[v].gap_after)) begin tick(); c++; end
        check("stall reached", 0, int'(all_stalled(vecs[v].gap_after)), 1);
        stall_chk = 1'b1;
        repeat (100) tick();
        stall_chk = 1'b0;
        avail = vecs[v].exp_words + 2;
      end

      if (vecs[v].restart_at > 0) begin
        repeat (vecs[v].restart_at) tick();
        pulse_start(~vecs[v].mode);
      end

      c = 0;
      while (c < 30000 && !all_done()) begin tick(); c++; end
      check("Done reached", 0, int'(all_done()), 1);
      repeat (5) tick();

      for (int k = 0; k < NI; k++) begin
        check("SELECT", k, int'(sel_w[k]), int'(vecs[v].exp_select));
        check("Done pulses", k, done_w_cnt[k], 1);
        check("words read", k, rd_ptr_w[k], vecs[v].exp_words);
        check("SR_CK rising edges", k, edges_w[k], 16 * vecs[v].exp_words);
        check("bitstream errors", k, bit_err_w[k], 0);
        check("timing errors", k, tim_err_w[k], 0);
        check("stall errors", k, stall_err_w[k], 0);
        check("SR_RSTB low cycles", k, rst_len_w[k], RST_C);
        if (vecs[v].gap_after == 0)
          check("load cycles", k, busy_cyc_w[k],
                RST_C + vecs[v].exp_words * (2 + 32 * HPS[k]) + 1);
        check("end SR_IN", k, int'(in_w[k]), 0);
        check("end SR_CK", k, int'(ck_w[k]), 0);
        check("end Busy", k, int'(busy_w[k]), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
